// File: rtl/debounce_edge.sv
// Debouncer with registered level output and single-cycle rise/fall strobes.
// Optional saturating press counter enabled by defining DEBOUNCE_PRESS_CNT_EN.
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic                 cnt_clear,
  output logic                 deb_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] press_count
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] stab_cnt, cnt_nx;
  logic          deb_nx, rise_nx, fall_nx;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nx = state;
    cnt_nx   = stab_cnt;
    deb_nx   = deb_out;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync_in) begin
          state_nx = WAIT_HI;
          cnt_nx   = SW'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_in) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (stab_cnt == LAST) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
          deb_nx   = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx   = stab_cnt + SW'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_in) begin
          state_nx = WAIT_LO;
          cnt_nx   = SW'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_in) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (stab_cnt == LAST) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          deb_nx   = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx   = stab_cnt + SW'(1);
        end
      end
      default: begin
        state_nx = STABLE_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are taken straight from flops; sync_in only reaches them through the next-state logic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state      <= STABLE_LO;
      stab_cnt   <= '0;
      deb_out    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      stab_cnt   <= cnt_nx;
      deb_out    <= deb_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
    end
  end

`ifdef DEBOUNCE_PRESS_CNT_EN
  // Clear has priority over a coincident rise strobe; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      press_count <= '0;
    end else if (rise_pulse && (press_count != '1)) begin
      press_count <= press_count + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign press_count      = '0;
`endif

endmodule
